// File: rtl/parking_pkg.sv
// Shared types and constants for the parking gate controller.
// PARKING_LOCKOUT_EN enables the wrong-password lockout in parking_ctrl.
package parking_pkg;

    typedef logic [1:0] state_t;
    localparam state_t StIdle    = 2'd0;
    localparam state_t StOpening = 2'd1;
    localparam state_t StClosing = 2'd2;

    typedef logic dir_t;
    localparam dir_t DirEntry = 1'b0;
    localparam dir_t DirExit  = 1'b1;

    localparam int unsigned PASS_TBL_LEN = 10;
    localparam int unsigned PASS_TBL_W   = 6;
    // Entry 0 is the rightmost element.
    localparam logic [PASS_TBL_LEN-1:0][PASS_TBL_W-1:0] PASSWORD = {
        6'd63, 6'd55, 6'd51, 6'd47, 6'd44, 6'd39, 6'd38, 6'd35, 6'd7, 6'd3
    };

    localparam int unsigned LOCK_TRIES  = 3;
    localparam int unsigned LOCK_CYCLES = 256;
    localparam int unsigned LOCK_W      = 9;

endpackage

// File: rtl/parking_pass_match.sv
// Combinational lookup of the keyed password against the fixed table.
module parking_pass_match
    import parking_pkg::*;
#(
    parameter int unsigned PASS_W   = 6,
    parameter int unsigned NUM_PASS = 10
) (
    input  logic [PASS_W-1:0] pass_i,
    output logic              match_o
);

    always_comb begin
        match_o = 1'b0;
        for (int i = 0; i < PASS_TBL_LEN; i++) begin
            if ((i < NUM_PASS) && (pass_i == PASS_W'(PASSWORD[i]))) begin
                match_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/parking_ctrl.sv
// Parking gate controller: password entry, exit handling, door FSM with timeout.
// Define PARKING_LOCKOUT_EN to lock entry after repeated wrong passwords.
module parking_ctrl
    import parking_pkg::*;
#(
    parameter int unsigned CAPACITY     = 10,
    parameter int unsigned CNT_W        = 4,
    parameter int unsigned PASS_W       = 6,
    parameter int unsigned NUM_PASS     = 10,
    parameter int unsigned OPEN_TIMEOUT = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              entrance_sen,
    input  logic [PASS_W-1:0] entrance_pass,
    input  logic              exit_sen,
    input  logic              door_max_open,
    input  logic              door_max_close,
    output logic              door_open,
    output logic              door_close,
    output logic              ok_pass,
    output logic              wrong_pass,
    output logic [CNT_W-1:0]  car_number,
    output logic              empty,
    output logic              full,
    output logic              door_fault
);

    localparam int unsigned TMR_W = $clog2(OPEN_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TmrLast = TMR_W'(OPEN_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CapMax  = CNT_W'(CAPACITY);

    state_t           state_q, state_d;
    dir_t             dir_q, dir_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             ent_prev_q;
    logic             ok_q, ok_d;
    logic             wrong_q, wrong_d;
    logic             fault_q, fault_d;
    logic             open_q, close_q;
    logic             ent_edge;
    logic             pass_ok;
    logic             locked;

    parking_pass_match #(
        .PASS_W   (PASS_W),
        .NUM_PASS (NUM_PASS)
    ) u_pass_match (
        .pass_i  (entrance_pass),
        .match_o (pass_ok)
    );

    assign ent_edge = entrance_sen & ~ent_prev_q;

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        count_d = count_q;
        tmr_d   = '0;
        ok_d    = 1'b0;
        wrong_d = 1'b0;
        fault_d = 1'b0;
        case (state_q)
            StIdle: begin
                // Exit has priority; a coincident entrance edge is dropped.
                if (exit_sen && !empty) begin
                    state_d = StOpening;
                    dir_d   = DirExit;
                end else if (ent_edge && !locked) begin
                    if (!pass_ok) begin
                        wrong_d = 1'b1;
                    end else if (!full) begin
                        ok_d    = 1'b1;
                        state_d = StOpening;
                        dir_d   = DirEntry;
                    end
                end
            end
            StOpening: begin
                if (door_max_open) begin
                    state_d = StClosing;
                end else if (tmr_q == TmrLast) begin
                    fault_d = 1'b1;
                    state_d = StClosing;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            StClosing: begin
                if (door_max_close) begin
                    state_d = StIdle;
                    if (dir_q == DirEntry) begin
                        if (count_q < CapMax) count_d = count_q + 1'b1;
                    end else begin
                        if (count_q != '0) count_d = count_q - 1'b1;
                    end
                end else if (tmr_q == TmrLast) begin
                    fault_d = 1'b1;
                    state_d = StIdle;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            dir_q      <= DirEntry;
            count_q    <= '0;
            tmr_q      <= '0;
            ent_prev_q <= 1'b0;
            ok_q       <= 1'b0;
            wrong_q    <= 1'b0;
            fault_q    <= 1'b0;
            open_q     <= 1'b0;
            close_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            count_q    <= count_d;
            tmr_q      <= tmr_d;
            ent_prev_q <= entrance_sen;
            ok_q       <= ok_d;
            wrong_q    <= wrong_d;
            fault_q    <= fault_d;
            open_q     <= (state_d == StOpening);
            close_q    <= (state_d == StClosing);
        end
    end

`ifdef PARKING_LOCKOUT_EN
    logic [1:0]        wcnt_q, wcnt_d;
    logic [LOCK_W-1:0] lock_q, lock_d;

    assign locked = (lock_q != '0);

    always_comb begin
        wcnt_d = wcnt_q;
        lock_d = locked ? lock_q - 1'b1 : lock_q;
        if (wrong_d) begin
            if (wcnt_q == 2'(LOCK_TRIES - 1)) begin
                wcnt_d = '0;
                lock_d = LOCK_W'(LOCK_CYCLES);
            end else begin
                wcnt_d = wcnt_q + 1'b1;
            end
        end else if (ok_d) begin
            wcnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt_q <= '0;
            lock_q <= '0;
        end else begin
            wcnt_q <= wcnt_d;
            lock_q <= lock_d;
        end
    end
`else
    assign locked = 1'b0;
`endif

    assign door_open  = open_q;
    assign door_close = close_q;
    assign ok_pass    = ok_q;
    assign wrong_pass = wrong_q;
    assign door_fault = fault_q;
    assign car_number = count_q;
    assign empty      = (count_q == '0);
    assign full       = (count_q == CapMax);

endmodule

// File: tb/tb_parking_ctrl.sv
// Directed self-checking bench for parking_ctrl.
module tb_parking_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       entrance_sen;
    logic [5:0] entrance_pass;
    logic       exit_sen;
    logic       door_max_open;
    logic       door_max_close;
    logic       door_open;
    logic       door_close;
    logic       ok_pass;
    logic       wrong_pass;
    logic [3:0] car_number;
    logic       empty;
    logic       full;
    logic       door_fault;

    int n_checks = 0;
    int n_pass   = 0;

    parking_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .entrance_sen   (entrance_sen),
        .entrance_pass  (entrance_pass),
        .exit_sen       (exit_sen),
        .door_max_open  (door_max_open),
        .door_max_close (door_max_close),
        .door_open      (door_open),
        .door_close     (door_close),
        .ok_pass        (ok_pass),
        .wrong_pass     (wrong_pass),
        .car_number     (car_number),
        .empty          (empty),
        .full           (full),
        .door_fault     (door_fault)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic door_cycle();
        door_max_open = 1'b1;
        step();
        door_max_open  = 1'b0;
        door_max_close = 1'b1;
        step();
        door_max_close = 1'b0;
    endtask

    task automatic car_in(input logic [5:0] pass);
        entrance_pass = pass;
        entrance_sen  = 1'b1;
        step();
        entrance_sen = 1'b0;
        step();
        door_cycle();
    endtask

    task automatic car_out();
        exit_sen = 1'b1;
        step();
        exit_sen = 1'b0;
        step();
        door_cycle();
    endtask

    initial begin
        rst = 1'b1;
        entrance_sen = 1'b0;
        entrance_pass = '0;
        exit_sen = 1'b0;
        door_max_open = 1'b0;
        door_max_close = 1'b0;
        step();
        step();
        chk("rst_count", car_number, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_motors", {door_open, door_close}, 0);
        chk("rst_pulses", {ok_pass, wrong_pass, door_fault}, 0);
        rst = 1'b0;

        // Exit request with empty lot is ignored.
        exit_sen = 1'b1;
        step();
        exit_sen = 1'b0;
        step();
        chk("exit_empty_door", door_open, 0);

        // Valid entry with pass 35.
        entrance_pass = 6'd35;
        entrance_sen  = 1'b1;
        step();
        chk("ok35_pulse", ok_pass, 1);
        chk("ok35_open", door_open, 1);
        entrance_sen = 1'b0;
        step();
        chk("ok35_pulse_end", ok_pass, 0);
        door_max_open = 1'b1;
        step();
        chk("ok35_close", {door_open, door_close}, 2'b01);
        door_max_open  = 1'b0;
        door_max_close = 1'b1;
        step();
        door_max_close = 1'b0;
        chk("ok35_count", car_number, 1);
        chk("ok35_empty", empty, 0);
        chk("ok35_idle", {door_open, door_close}, 0);

        // Wrong password, then held sensor must not retrigger.
        entrance_pass = 6'd4;
        entrance_sen  = 1'b1;
        step();
        chk("wrong_pulse", wrong_pass, 1);
        chk("wrong_door", door_open, 0);
        step();
        chk("wrong_held", wrong_pass, 0);
        step();
        chk("wrong_held2", wrong_pass, 0);
        chk("wrong_count", car_number, 1);
        entrance_sen = 1'b0;
        step();

        // Fill to capacity.
        for (int i = 0; i < 9; i++) car_in(6'd3);
        chk("fill_count", car_number, 10);
        chk("fill_full", full, 1);
        entrance_pass = 6'd63;
        entrance_sen  = 1'b1;
        step();
        chk("full_no_pulse", {ok_pass, wrong_pass}, 0);
        chk("full_no_door", door_open, 0);
        entrance_sen = 1'b0;
        step();
        car_out();
        chk("exit_count9", car_number, 9);
        chk("exit_full0", full, 0);

        for (int i = 0; i < 4; i++) car_out();
        chk("count5", car_number, 5);

        // Simultaneous exit and entrance edge: exit wins.
        entrance_pass = 6'd35;
        entrance_sen  = 1'b1;
        exit_sen      = 1'b1;
        step();
        chk("sim_no_ok", ok_pass, 0);
        chk("sim_open", door_open, 1);
        entrance_sen = 1'b0;
        exit_sen     = 1'b0;
        step();
        door_cycle();
        chk("sim_count4", car_number, 4);

        // Timeout in OPENING.
        entrance_pass = 6'd7;
        entrance_sen  = 1'b1;
        step();
        chk("to_ok", ok_pass, 1);
        entrance_sen = 1'b0;
        for (int i = 0; i < 998; i++) step();
        step();
        chk("to_not_yet", {door_fault, door_open}, 2'b01);
        step();
        chk("to_fault", door_fault, 1);
        chk("to_closing", {door_open, door_close}, 2'b01);
        chk("to_count", car_number, 4);
        step();
        chk("to_fault_end", door_fault, 0);

        // Reset mid-CLOSING.
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_motors", {door_open, door_close}, 0);
        chk("rst_mid_count", car_number, 0);
        chk("rst_mid_empty", empty, 1);

`ifdef PARKING_LOCKOUT_EN
        step();
        for (int i = 0; i < 3; i++) begin
            entrance_pass = 6'd4;
            entrance_sen  = 1'b1;
            step();
            chk("lock_wrong", wrong_pass, 1);
            entrance_sen = 1'b0;
            step();
        end
        entrance_pass = 6'd3;
        entrance_sen  = 1'b1;
        step();
        chk("lock_ignored", {ok_pass, door_open}, 0);
        entrance_sen = 1'b0;
        for (int i = 0; i < 260; i++) step();
        entrance_sen = 1'b1;
        step();
        chk("lock_released", ok_pass, 1);
        entrance_sen = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
